// File: rtl/eth_packet_framer_if.sv
// Framer bus bundle: aggregator FIFO read side plus the framed valid/ready stream to the MAC.
// The framer connects through the master modport; the FIFO/MAC side uses slave.
interface eth_packet_framer_if;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  modport master (
    input  fifo_dout, fifo_empty, m_tready,
    output fifo_rd_en, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output fifo_dout, fifo_empty, m_tready,
    input  fifo_rd_en, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/eth_packet_framer.sv
// Buffers aggregator FIFO words and emits header/payload/trailer packets on a valid/ready stream.
// Optional feature macro: CHECKSUM_EN (XOR trailer); without it the trailer is a fixed constant.
module eth_packet_framer #(
  parameter int unsigned PKT_WORDS = 256,
  parameter int unsigned TIMEOUT   = 20000,
  parameter logic [7:0]  HDR_MAGIC = 8'hA5
) (
  input  logic                       fifo_rd_clk,
  input  logic                       rst,
  eth_packet_framer_if.master        bus,
  output logic [15:0]                pkt_count,
  output logic                       busy
);

  localparam int unsigned CNT_W  = $clog2(PKT_WORDS + 1);
  localparam int unsigned ADDR_W = $clog2(PKT_WORDS);
  localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_HEADER,
    ST_PAYLOAD,
    ST_TRAILER
  } state_t;

  state_t             r_state,   w_state;
  logic [CNT_W-1:0]   r_wr_cnt,  w_wr_cnt;
  logic [TMR_W-1:0]   r_timer,   w_timer;
  logic [CNT_W-1:0]   r_len,     w_len;
  logic [CNT_W-1:0]   r_rd_idx,  w_rd_idx;
  logic [7:0]         r_seq,     w_seq;
  logic [15:0]        r_pkt_cnt, w_pkt_cnt;
  logic [31:0]        r_tdata,   w_tdata;
  logic               r_tvalid,  w_tvalid;
  logic               r_tlast,   w_tlast;
  logic               r_busy,    w_busy;
  logic               r_rd_pend;
  logic               w_rd_en;
  logic               w_hs;
  logic               w_timed_out;
  logic [31:0]        w_trailer;

  logic [31:0]        r_buf [PKT_WORDS];

  assign w_hs        = r_tvalid & bus.m_tready;
  assign w_timed_out = (r_timer >= TMR_W'(TIMEOUT));

`ifdef CHECKSUM_EN
  logic [31:0] r_csum, w_csum;

  // Running XOR of handshaken header/payload; the last payload word is folded in at trailer load.
  always_comb begin
    w_csum = r_csum;
    if (w_hs) begin
      case (r_state)
        ST_HEADER:  w_csum = r_tdata;
        ST_PAYLOAD: w_csum = r_csum ^ r_tdata;
        default:    w_csum = r_csum;
      endcase
    end
  end

  assign w_trailer = r_csum ^ r_tdata;

  always_ff @(posedge fifo_rd_clk) begin
    if (rst) r_csum <= '0;
    else     r_csum <= w_csum;
  end
`else
  assign w_trailer = 32'hC0DE_5A5A;
`endif

  // Next-state and next-output logic; stream outputs are loaded one cycle ahead of presentation.
  always_comb begin
    w_state   = r_state;
    w_wr_cnt  = r_wr_cnt;
    w_timer   = r_timer;
    w_len     = r_len;
    w_rd_idx  = r_rd_idx;
    w_seq     = r_seq;
    w_pkt_cnt = r_pkt_cnt;
    w_tdata   = r_tdata;
    w_tvalid  = r_tvalid;
    w_tlast   = r_tlast;
    w_rd_en   = 1'b0;

    case (r_state)
      ST_FILL: begin
        w_rd_en = ~rst & ~bus.fifo_empty & ~w_timed_out &
                  ((r_wr_cnt + CNT_W'(r_rd_pend)) < CNT_W'(PKT_WORDS));
        if (r_rd_pend) w_wr_cnt = r_wr_cnt + CNT_W'(1);
        if ((r_wr_cnt != '0) && !w_timed_out) w_timer = r_timer + TMR_W'(1);
        if (!r_rd_pend &&
            ((r_wr_cnt == CNT_W'(PKT_WORDS)) || (w_timed_out && (r_wr_cnt != '0)))) begin
          w_state  = ST_HEADER;
          w_len    = r_wr_cnt;
          w_rd_idx = '0;
          w_tvalid = 1'b1;
          w_tlast  = 1'b0;
          w_tdata  = {HDR_MAGIC, r_seq, 16'(r_wr_cnt)};
        end
      end
      ST_HEADER: begin
        if (w_hs) begin
          w_state  = ST_PAYLOAD;
          w_tdata  = r_buf[ADDR_W'(0)];
          w_rd_idx = CNT_W'(1);
        end
      end
      ST_PAYLOAD: begin
        if (w_hs) begin
          if (r_rd_idx == r_len) begin
            w_state = ST_TRAILER;
            w_tlast = 1'b1;
            w_tdata = w_trailer;
          end else begin
            w_tdata  = r_buf[r_rd_idx[ADDR_W-1:0]];
            w_rd_idx = r_rd_idx + CNT_W'(1);
          end
        end
      end
      ST_TRAILER: begin
        if (w_hs) begin
          w_state   = ST_FILL;
          w_tvalid  = 1'b0;
          w_tlast   = 1'b0;
          w_seq     = r_seq + 8'd1;
          w_pkt_cnt = r_pkt_cnt + 16'd1;
          w_wr_cnt  = '0;
          w_timer   = '0;
        end
      end
      default: w_state = ST_FILL;
    endcase

    w_busy = (w_state != ST_FILL) || (w_wr_cnt != '0);
  end

  always_ff @(posedge fifo_rd_clk) begin
    if (rst) begin
      r_state   <= ST_FILL;
      r_wr_cnt  <= '0;
      r_timer   <= '0;
      r_len     <= '0;
      r_rd_idx  <= '0;
      r_seq     <= '0;
      r_pkt_cnt <= '0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_busy    <= 1'b0;
      r_rd_pend <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_wr_cnt  <= w_wr_cnt;
      r_timer   <= w_timer;
      r_len     <= w_len;
      r_rd_idx  <= w_rd_idx;
      r_seq     <= w_seq;
      r_pkt_cnt <= w_pkt_cnt;
      r_tdata   <= w_tdata;
      r_tvalid  <= w_tvalid;
      r_tlast   <= w_tlast;
      r_busy    <= w_busy;
      r_rd_pend <= w_rd_en;
    end
  end

  // Non-FWFT FIFO: data for a read arrives the following cycle and lands at the current fill index.
  always_ff @(posedge fifo_rd_clk) begin
    if (r_rd_pend) r_buf[r_wr_cnt[ADDR_W-1:0]] <= bus.fifo_dout;
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_tdata    = r_tdata;
  assign bus.m_tvalid   = r_tvalid;
  assign bus.m_tlast    = r_tlast;
  assign pkt_count      = r_pkt_cnt;
  assign busy           = r_busy;

endmodule

// File: tb/tb_eth_packet_framer.sv
// Bench for eth_packet_framer: queue-based FIFO model, packet-level reference model, random ready.
module tb_eth_packet_framer;
  localparam int unsigned PW = 16;
  localparam int unsigned TO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pkt_count;
  logic        busy;

  always #5 clk = ~clk;

  eth_packet_framer_if bus();

  eth_packet_framer #(.PKT_WORDS(PW), .TIMEOUT(TO), .HDR_MAGIC(8'hA5)) dut (
    .fifo_rd_clk(clk),
    .rst        (rst),
    .bus        (bus),
    .pkt_count  (pkt_count),
    .busy       (busy)
  );

  int checks   = 0;
  int failures = 0;
  int rd_on_empty = 0;
  int exp_pkts = 0;
  logic [7:0]  exp_seq = 8'd0;
  logic [31:0] fq[$];
  logic [31:0] pq[$];
  logic [31:0] pay_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];

  // Standard FIFO: data one cycle after rd_en; pending pushes become visible at the next edge.
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      if (fq.size() > 0) bus.fifo_dout <= fq.pop_front();
      else               rd_on_empty <= rd_on_empty + 1;
    end
    while (pq.size() > 0) fq.push_back(pq.pop_front());
    bus.fifo_empty <= (fq.size() == 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference packet: {tlast, data} for header, payload words, trailer.
  function automatic void make_expected(input logic [7:0] seq);
    logic [31:0] hdr;
    logic [31:0] x;
    exp_q.delete();
    hdr = {8'hA5, seq, 16'(pay_q.size())};
    exp_q.push_back({1'b0, hdr});
    x = hdr;
    foreach (pay_q[i]) begin
      exp_q.push_back({1'b0, pay_q[i]});
      x = x ^ pay_q[i];
    end
`ifdef CHECKSUM_EN
    exp_q.push_back({1'b1, x});
`else
    exp_q.push_back({1'b1, 32'hC0DE_5A5A});
`endif
  endfunction

  function automatic int first_diff();
    int n;
    n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i >= got_q.size() || i >= exp_q.size()) return i;
      if (got_q[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [32:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 33'h0;
  endfunction

  function automatic logic [32:0] exp_at(input int i);
    return (i < exp_q.size()) ? exp_q[i] : 33'h0;
  endfunction

  task automatic push_pay();
    foreach (pay_q[i]) pq.push_back(pay_q[i]);
  endtask

  task automatic rand_pay(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back($urandom());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.m_tready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_seq  = 8'd0;
    exp_pkts = 0;
  endtask

  task automatic wait_valid(input int max_cyc, output int cyc, output bit to);
    cyc = 0;
    to  = 1'b0;
    while (!bus.m_tvalid) begin
      @(negedge clk);
      cyc++;
      if (cyc > max_cyc) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  // Gathers n handshaken words with random ready; counts any change of a stalled word.
  task automatic collect(input int n, input int pct, input int max_cyc,
                         output int stall_err, output bit to);
    int          cyc;
    bit          prev_stall;
    logic [31:0] pdata;
    logic        plast;
    got_q.delete();
    stall_err  = 0;
    to         = 1'b0;
    cyc        = 0;
    prev_stall = 1'b0;
    pdata      = '0;
    plast      = 1'b0;
    while (got_q.size() < n) begin
      @(negedge clk);
      if (prev_stall && (!bus.m_tvalid || bus.m_tdata !== pdata || bus.m_tlast !== plast))
        stall_err++;
      bus.m_tready = ($urandom_range(99) < pct);
      if (bus.m_tvalid && bus.m_tready) got_q.push_back({bus.m_tlast, bus.m_tdata});
      prev_stall = bus.m_tvalid && !bus.m_tready;
      pdata      = bus.m_tdata;
      plast      = bus.m_tlast;
      cyc++;
      if (cyc > max_cyc) begin
        to = 1'b1;
        break;
      end
    end
    @(negedge clk);
    bus.m_tready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.m_tready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b expected 0", bus.m_tvalid); end
    checks++; if (bus.m_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast: got %b expected 0", bus.m_tlast); end
    checks++; if (bus.m_tdata !== 32'h0) begin failures++; $display("FAIL reset_tdata: got %h expected 0", bus.m_tdata); end
    checks++; if (pkt_count !== 16'h0) begin failures++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b expected 0", bus.fifo_rd_en); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle();
    repeat (3 * TO / 2) @(negedge clk);
    checks++; if (bus.m_tvalid !== 1'b0) begin failures++; $display("FAIL idle_tvalid: got %b expected 0", bus.m_tvalid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_full();
    int se; bit to; int idx;
    pay_q.delete();
    for (int i = 1; i <= 16; i++) pay_q.push_back(32'(i));
    push_pay();
    make_expected(exp_seq);
    collect(18, 100, 200, se, to);
    exp_seq++; exp_pkts++;
    idx = first_diff();
    checks++; if (to || idx != -1) begin failures++; $display("FAIL full_pkt word %0d: got %h expected %h (timeout=%0b)", idx, got_at(idx), exp_at(idx), to); end
    checks++; if (bus.m_tvalid !== 1'b0) begin failures++; $display("FAIL full_tvalid_drop: got %b expected 0", bus.m_tvalid); end
    checks++; if (pkt_count !== 16'(exp_pkts)) begin failures++; $display("FAIL full_pkt_count: got %0d expected %0d", pkt_count, exp_pkts); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy: got %b expected 0", busy); end
  endtask

  task automatic test_timeout();
    int se; bit to; int idx; int cyc;
    pay_q.delete();
    pay_q.push_back(32'hAA); pay_q.push_back(32'hBB); pay_q.push_back(32'hCC);
    push_pay();
    make_expected(exp_seq);
    wait_valid(3 * TO, cyc, to);
    checks++; if (to || cyc < int'(TO) || cyc > int'(TO) + 15) begin failures++; $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d", cyc, TO, TO + 15); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL timeout_busy: got %b expected 1", busy); end
    collect(5, 100, 100, se, to);
    exp_seq++; exp_pkts++;
    idx = first_diff();
    checks++; if (to || idx != -1) begin failures++; $display("FAIL timeout_pkt word %0d: got %h expected %h (timeout=%0b)", idx, got_at(idx), exp_at(idx), to); end
    checks++; if (pkt_count !== 16'(exp_pkts)) begin failures++; $display("FAIL timeout_pkt_count: got %0d expected %0d", pkt_count, exp_pkts); end
  endtask

  task automatic test_backpressure();
    int se; bit to; int idx;
    rand_pay(16);
    push_pay();
    make_expected(exp_seq);
    collect(18, 50, 1000, se, to);
    exp_seq++; exp_pkts++;
    idx = first_diff();
    checks++; if (to || idx != -1) begin failures++; $display("FAIL bp_pkt word %0d: got %h expected %h (timeout=%0b)", idx, got_at(idx), exp_at(idx), to); end
    checks++; if (se != 0) begin failures++; $display("FAIL bp_stall_stable: got %0d changes expected 0", se); end
    checks++; if (pkt_count !== 16'(exp_pkts)) begin failures++; $display("FAIL bp_pkt_count: got %0d expected %0d", pkt_count, exp_pkts); end
    checks++; if (rd_on_empty != 0) begin failures++; $display("FAIL rd_on_empty: got %0d expected 0", rd_on_empty); end
  endtask

  task automatic test_sequence();
    int se; bit to; int idx;
    logic [31:0] src[$];
    do_reset();
    for (int i = 0; i < 40; i++) src.push_back($urandom());
    foreach (src[i]) pq.push_back(src[i]);
    for (int k = 0; k < 3; k++) begin
      pay_q.delete();
      for (int i = 16 * k; i < 16 * k + 16 && i < 40; i++) pay_q.push_back(src[i]);
      make_expected(exp_seq);
      collect(pay_q.size() + 2, 100, 3 * TO, se, to);
      exp_seq++; exp_pkts++;
      idx = first_diff();
      checks++; if (to || idx != -1) begin failures++; $display("FAIL seq_pkt%0d word %0d: got %h expected %h (timeout=%0b)", k, idx, got_at(idx), exp_at(idx), to); end
    end
    checks++; if (pkt_count !== 16'(exp_pkts)) begin failures++; $display("FAIL seq_pkt_count: got %0d expected %0d", pkt_count, exp_pkts); end
  endtask

  task automatic test_wrap();
    int se; bit to; int idx;
    do_reset();
    for (int p = 0; p < 257; p++) begin
      rand_pay(16);
      push_pay();
      make_expected(exp_seq);
      collect(18, 100, 200, se, to);
      exp_seq++; exp_pkts++;
      idx = first_diff();
      checks++; if (to || idx != -1) begin failures++; $display("FAIL wrap_pkt%0d word %0d: got %h expected %h (timeout=%0b)", p, idx, got_at(idx), exp_at(idx), to); end
    end
    checks++; if (got_at(0) !== {1'b0, 8'hA5, 8'h00, 16'h0010}) begin failures++; $display("FAIL wrap_seq0_header: got %h expected %h", got_at(0), {1'b0, 32'hA500_0010}); end
    checks++; if (pkt_count !== 16'(exp_pkts)) begin failures++; $display("FAIL wrap_pkt_count: got %0d expected %0d", pkt_count, exp_pkts); end
  endtask

  task automatic test_reset_mid();
    int se; bit to; int idx;
    rand_pay(16);
    push_pay();
    make_expected(exp_seq);
    while (exp_q.size() > 6) void'(exp_q.pop_back());
    collect(6, 100, 200, se, to);
    idx = first_diff();
    checks++; if (to || idx != -1) begin failures++; $display("FAIL mid_prefix word %0d: got %h expected %h (timeout=%0b)", idx, got_at(idx), exp_at(idx), to); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.m_tvalid !== 1'b0) begin failures++; $display("FAIL mid_tvalid: got %b expected 0", bus.m_tvalid); end
    checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL mid_rd_en: got %b expected 0", bus.fifo_rd_en); end
    checks++; if (pkt_count !== 16'h0) begin failures++; $display("FAIL mid_pkt_count: got %0d expected 0", pkt_count); end
    rst = 1'b0;
    exp_seq  = 8'd0;
    exp_pkts = 0;
    @(negedge clk);
    rand_pay(16);
    push_pay();
    make_expected(exp_seq);
    collect(18, 100, 200, se, to);
    exp_seq++; exp_pkts++;
    idx = first_diff();
    checks++; if (to || idx != -1) begin failures++; $display("FAIL mid_next_pkt word %0d: got %h expected %h (timeout=%0b)", idx, got_at(idx), exp_at(idx), to); end
    checks++; if (pkt_count !== 16'(exp_pkts)) begin failures++; $display("FAIL mid_next_pkt_count: got %0d expected %0d", pkt_count, exp_pkts); end
  endtask

  initial begin
    bus.m_tready = 1'b0;
    test_reset();
    test_idle();
    test_full();
    test_timeout();
    test_backpressure();
    test_sequence();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
